// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lends the single execute-stage ALU to
// one of two requesters (port 0: IDU execute, port 1: CSR/branch helper),
// drives the ALU until it reports done (or a watchdog expires) and returns the
// registered result over a valid/ready response handshake.
module alu_arbiter #(
  parameter int TIMEOUT = 15  // max BUSY cycles waiting for alu_done, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  // request port 0 (IDU execute path)
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [4:0]  req_ctrl_0,
  input  logic [31:0] req_src1_0,
  input  logic [31:0] req_src2_0,
  input  logic [31:0] req_csr_0,
  input  logic [31:0] req_inst_0,
  // request port 1 (CSR/branch helper path)
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [4:0]  req_ctrl_1,
  input  logic [31:0] req_src1_1,
  input  logic [31:0] req_src2_1,
  input  logic [31:0] req_csr_1,
  input  logic [31:0] req_inst_1,
  // response (shared result bus, per-port valid/ready)
  output logic        resp_valid_0,
  input  logic        resp_ready_0,
  output logic        resp_valid_1,
  input  logic        resp_ready_1,
  output logic [31:0] resp_result,
  output logic        resp_err,
  // ALU side
  output logic        alu_go,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [31:0] alu_csr,
  output logic [31:0] alu_inst,
  input  logic [31:0] alu_result,
  input  logic        alu_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // One ALU operation as presented by a requester.
  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] csr;
    logic [31:0] inst;
  } op_t;

  // Watchdog fires on the last allowed BUSY cycle.
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_prio;    // favoured port when both request
  logic        r_owner;   // port whose operation is in flight
  logic [7:0]  r_cnt;     // BUSY cycles elapsed for the current operation
  op_t         r_op;      // operands held stable toward the ALU
  logic [31:0] r_result;
  logic        r_err;

  op_t         w_req0;
  op_t         w_req1;
  op_t         w_win_op;
  logic        w_win0;
  logic        w_win1;
  logic        w_accept;
  logic        w_resp_hs;
  logic        w_timeout;

  assign w_req0 = '{ctrl: req_ctrl_0, src1: req_src1_0, src2: req_src2_0,
                    csr: req_csr_0, inst: req_inst_0};
  assign w_req1 = '{ctrl: req_ctrl_1, src1: req_src1_1, src2: req_src2_1,
                    csr: req_csr_1, inst: req_inst_1};

  // Grant: a lone requester wins; on contention the favoured port wins.
  always_comb begin
    w_win0   = req_valid_0 & (~req_valid_1 | ~r_prio);
    w_win1   = req_valid_1 & (~req_valid_0 |  r_prio);
    req_ready_0 = (r_state == IDLE) & w_win0;
    req_ready_1 = (r_state == IDLE) & w_win1;
    w_accept = req_ready_0 | req_ready_1;
    w_win_op = req_ready_1 ? w_req1 : w_req0;
  end

  // Response handshake only counts on the owning port; the other ready is ignored.
  assign w_resp_hs = (r_state == RESP) & (r_owner ? resp_ready_1 : resp_ready_0);
  assign w_timeout = (r_cnt == LP_TO_LAST);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (alu_done || w_timeout) w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operand capture, watchdog, result capture and priority update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_cnt    <= 8'd0;
      r_op     <= '0;
      r_result <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_win_op;
            r_owner <= req_ready_1;
            r_cnt   <= 8'd0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          // done takes precedence over a watchdog expiring in the same cycle
          if (alu_done) begin
            r_result <= alu_result;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= 32'd0;
            r_err    <= 1'b1;
          end
        end
        RESP: begin
          if (w_resp_hs) r_prio <= ~r_owner;
        end
        default: ;
      endcase
    end
  end

  assign alu_go       = (r_state == BUSY);
  assign alu_ctrl     = r_op.ctrl;
  assign alu_src1     = r_op.src1;
  assign alu_src2     = r_op.src2;
  assign alu_csr      = r_op.csr;
  assign alu_inst     = r_op.inst;

  assign resp_valid_0 = (r_state == RESP) & ~r_owner;
  assign resp_valid_1 = (r_state == RESP) &  r_owner;
  assign resp_result  = r_result;
  assign resp_err     = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a
// transaction-level round-robin model and a behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [4:0]  req_ctrl_0, req_ctrl_1;
  logic [31:0] req_src1_0, req_src2_0, req_csr_0, req_inst_0;
  logic [31:0] req_src1_1, req_src2_1, req_csr_1, req_inst_1;
  logic        resp_valid_0, resp_ready_0, resp_valid_1, resp_ready_1;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        alu_go, alu_done;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_src1, alu_src2, alu_csr, alu_inst, alu_result;

  // second instance (TIMEOUT=2) shares the request/response inputs
  logic        d2_req_ready_0, d2_req_ready_1, d2_resp_valid_0, d2_resp_valid_1;
  logic [31:0] d2_resp_result;
  logic        d2_resp_err, d2_alu_go, d2_alu_done;
  logic [4:0]  d2_alu_ctrl;
  logic [31:0] d2_alu_src1, d2_alu_src2, d2_alu_csr, d2_alu_inst, d2_alu_result;

  logic auto_done = 1'b1, man_done = 1'b0, done_q = 1'b0, d2_done_q = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // behavioural ALU used both as the DUT's ALU and as the expected-value source
  function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cs,
                                         input logic [31:0] ins);
    case (c[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return cs ^ b;
      default: return a << ins[24:20];
    endcase
  endfunction

  assign alu_result    = alu_fn(alu_ctrl, alu_src1, alu_src2, alu_csr, alu_inst);
  assign alu_done      = done_q | man_done;
  assign d2_alu_result = alu_fn(d2_alu_ctrl, d2_alu_src1, d2_alu_src2, d2_alu_csr, d2_alu_inst);
  assign d2_alu_done   = d2_done_q;

  // ALU finishes one cycle after start
  always @(posedge clk) begin
    done_q    <= auto_done & alu_go;
    d2_done_q <= d2_alu_go;
  end

  alu_arbiter #(.TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_ctrl_0(req_ctrl_0),
    .req_src1_0(req_src1_0), .req_src2_0(req_src2_0), .req_csr_0(req_csr_0), .req_inst_0(req_inst_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_ctrl_1(req_ctrl_1),
    .req_src1_1(req_src1_1), .req_src2_1(req_src2_1), .req_csr_1(req_csr_1), .req_inst_1(req_inst_1),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_err(resp_err),
    .alu_go(alu_go), .alu_ctrl(alu_ctrl), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_csr(alu_csr), .alu_inst(alu_inst), .alu_result(alu_result), .alu_done(alu_done)
  );

  alu_arbiter #(.TIMEOUT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(d2_req_ready_0), .req_ctrl_0(req_ctrl_0),
    .req_src1_0(req_src1_0), .req_src2_0(req_src2_0), .req_csr_0(req_csr_0), .req_inst_0(req_inst_0),
    .req_valid_1(req_valid_1), .req_ready_1(d2_req_ready_1), .req_ctrl_1(req_ctrl_1),
    .req_src1_1(req_src1_1), .req_src2_1(req_src2_1), .req_csr_1(req_csr_1), .req_inst_1(req_inst_1),
    .resp_valid_0(d2_resp_valid_0), .resp_ready_0(resp_ready_0),
    .resp_valid_1(d2_resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_result(d2_resp_result), .resp_err(d2_resp_err),
    .alu_go(d2_alu_go), .alu_ctrl(d2_alu_ctrl), .alu_src1(d2_alu_src1), .alu_src2(d2_alu_src2),
    .alu_csr(d2_alu_csr), .alu_inst(d2_alu_inst), .alu_result(d2_alu_result), .alu_done(d2_alu_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pending requests held by the stimulus (index = port)
  logic        pend [2];
  logic [4:0]  qc   [2];
  logic [31:0] qa [2], qb [2], qs [2], qi [2];

  task automatic new_req(input int p);
    pend[p] = 1'b1;
    qc[p] = 5'($urandom_range(0, 3));
    qa[p] = $urandom; qb[p] = $urandom; qs[p] = $urandom; qi[p] = $urandom;
  endtask

  task automatic drive();
    req_valid_0 = pend[0]; req_ctrl_0 = qc[0]; req_src1_0 = qa[0];
    req_src2_0 = qb[0]; req_csr_0 = qs[0]; req_inst_0 = qi[0];
    req_valid_1 = pend[1]; req_ctrl_1 = qc[1]; req_src1_1 = qa[1];
    req_src2_1 = qb[1]; req_csr_1 = qs[1]; req_inst_1 = qi[1];
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          hold;
    logic        win;
    logic        mp;
    logic [31:0] exp;

    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; qc[p] = '0; qa[p] = '0; qb[p] = '0; qs[p] = '0; qi[p] = '0;
    end
    drive();
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    rst = 1'b1;
    step(); step();

    // reset values
    chk("rst_flags", {26'd0, resp_valid_0, resp_valid_1, resp_err, alu_go, req_ready_0, req_ready_1}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_ctrl", {27'd0, alu_ctrl}, 32'd0);
    chk("rst_ops", alu_src1 | alu_src2 | alu_csr | alu_inst, 32'd0);
    rst = 1'b0;
    step();

    // single request on port 0: 5 + 7, minimum latency; TIMEOUT=2 copy sees done on its last cycle
    req_valid_0 = 1'b1; req_ctrl_0 = 5'd0; req_src1_0 = 32'd5; req_src2_0 = 32'd7;
    #1;
    chk("t1_ready0", req_ready_0, 1);
    chk("t1_ready1", req_ready_1, 0);
    step(); req_valid_0 = 1'b0; #1;
    chk("t1_go", alu_go, 1);
    chk("t1_src1", alu_src1, 32'd5);
    chk("t1_src2", alu_src2, 32'd7);
    chk("t1_busy_rdy", req_ready_0, 0);
    step();
    chk("t1_no_resp_yet", resp_valid_0, 0);
    step();
    chk("t1_rv0", resp_valid_0, 1);
    chk("t1_rv1", resp_valid_1, 0);
    chk("t1_result", resp_result, 32'd12);
    chk("t1_err", resp_err, 0);
    chk("t1_go_off", alu_go, 0);
    chk("t2_coinc_rv0", d2_resp_valid_0, 1);
    chk("t2_coinc_result", d2_resp_result, 32'd12);
    chk("t2_coinc_err", d2_resp_err, 0);
    resp_ready_0 = 1'b1; step(); resp_ready_0 = 1'b0;
    chk("t1_idle", resp_valid_0, 0);

    // backpressure on port 1 while port 0 waits
    req_valid_1 = 1'b1; req_ctrl_1 = 5'd1; req_src1_1 = 32'd100; req_src2_1 = 32'd58;
    #1;
    chk("bp_ready1", req_ready_1, 1);
    step(); req_valid_1 = 1'b0;
    req_valid_0 = 1'b1; req_ctrl_0 = 5'd0; req_src1_0 = 32'd1; req_src2_0 = 32'd2;
    step(); step();
    chk("bp_rv1", resp_valid_1, 1);
    chk("bp_result", resp_result, 32'd42);
    for (int i = 0; i < 5; i++) begin
      resp_ready_0 = 1'b1;  // non-owner ready must be ignored
      #1;
      chk("bp_hold_rv1", resp_valid_1, 1);
      chk("bp_hold_rv0", resp_valid_0, 0);
      chk("bp_hold_result", resp_result, 32'd42);
      chk("bp_hold_rdy0", req_ready_0, 0);
      step();
    end
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b1;
    #1;
    chk("bp_still_rv1", resp_valid_1, 1);
    step(); resp_ready_1 = 1'b0; #1;
    chk("bp_idle_rv1", resp_valid_1, 0);
    chk("bp_idle_rdy0", req_ready_0, 1);
    step(); req_valid_0 = 1'b0;
    step(); step();
    chk("bp_next_rv0", resp_valid_0, 1);
    chk("bp_next_result", resp_result, 32'd3);
    resp_ready_0 = 1'b1; step(); resp_ready_0 = 1'b0;

    // done on the last watchdog cycle (TIMEOUT=4): done wins
    auto_done = 1'b0;
    req_valid_1 = 1'b1; req_ctrl_1 = 5'd2; req_src2_1 = 32'h0000_0f0f; req_csr_1 = 32'h0000_ff00;
    #1;
    chk("co_ready1", req_ready_1, 1);
    step(); req_valid_1 = 1'b0;
    step(); step(); step();
    man_done = 1'b1;
    #1;
    chk("co_go", alu_go, 1);
    chk("co_no_resp", resp_valid_1, 0);
    step(); man_done = 1'b0; #1;
    chk("co_rv1", resp_valid_1, 1);
    chk("co_err", resp_err, 0);
    chk("co_result", resp_result, 32'h0000_f00f);
    resp_ready_1 = 1'b1; step(); resp_ready_1 = 1'b0;

    // timeout on port 0, then late done pulses are dropped
    req_valid_0 = 1'b1; req_ctrl_0 = 5'd0; req_src1_0 = 32'd9; req_src2_0 = 32'd9;
    #1;
    chk("to_ready0", req_ready_0, 1);
    step(); req_valid_0 = 1'b0;
    step(); step(); step();
    chk("to_go_last", alu_go, 1);
    chk("to_no_resp", resp_valid_0, 0);
    step();
    chk("to_rv0", resp_valid_0, 1);
    chk("to_result", resp_result, 32'd0);
    chk("to_err", resp_err, 1);
    chk("to_go_off", alu_go, 0);
    man_done = 1'b1; step(); man_done = 1'b0; #1;
    chk("to_late_rv0", resp_valid_0, 1);
    chk("to_late_err", resp_err, 1);
    chk("to_late_result", resp_result, 32'd0);
    resp_ready_0 = 1'b1; step(); resp_ready_0 = 1'b0;
    man_done = 1'b1; step(); man_done = 1'b0; #1;
    chk("to_idle_go", alu_go, 0);
    chk("to_idle_rv", {31'd0, resp_valid_0 | resp_valid_1}, 0);

    // reset mid-BUSY clears everything including the priority pointer (currently 1)
    req_valid_1 = 1'b1; req_ctrl_1 = 5'd3; req_src1_1 = 32'hdead; req_inst_1 = 32'h0010_0000;
    #1;
    chk("rb_ready1", req_ready_1, 1);
    step(); req_valid_1 = 1'b0;
    step();
    chk("rb_busy", alu_go, 1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("rb_flags", {26'd0, resp_valid_0, resp_valid_1, resp_err, alu_go, req_ready_0, req_ready_1}, 32'd0);
    chk("rb_result", resp_result, 32'd0);
    chk("rb_ctrl", {27'd0, alu_ctrl}, 32'd0);
    chk("rb_ops", alu_src1 | alu_src2 | alu_csr | alu_inst, 32'd0);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1;
    chk("rb_prio_rdy0", req_ready_0, 1);
    chk("rb_prio_rdy1", req_ready_1, 0);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    step();

    // randomized traffic vs transaction-level round-robin model
    auto_done = 1'b1;
    mp = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (!pend[0] && (t < 4 || $urandom_range(0, 2) != 0)) new_req(0);
      if (!pend[1] && (t < 4 || $urandom_range(0, 2) != 0)) new_req(1);
      if (!pend[0] && !pend[1]) new_req(0);
      drive();
      #1;
      win = (pend[0] && pend[1]) ? mp : pend[1];
      chk("rr_rdy0", req_ready_0, (win == 1'b0));
      chk("rr_rdy1", req_ready_1, (win == 1'b1));
      exp = alu_fn(qc[win], qa[win], qb[win], qs[win], qi[win]);
      step();
      pend[win] = 1'b0;
      drive();
      n = 0;
      while (!(resp_valid_0 || resp_valid_1) && n < 12) begin
        step();
        n++;
      end
      chk("rr_latency", n, 2);
      chk("rr_rv0", resp_valid_0, (win == 1'b0));
      chk("rr_rv1", resp_valid_1, (win == 1'b1));
      chk("rr_result", resp_result, exp);
      chk("rr_err", resp_err, 0);
      hold = (t < 4) ? 0 : $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        if (win) resp_ready_0 = 1'b1; else resp_ready_1 = 1'b1;
        step();
        chk("rr_hold_valid", win ? resp_valid_1 : resp_valid_0, 1);
        chk("rr_hold_result", resp_result, exp);
        chk("rr_hold_rdy", {30'd0, req_ready_0, req_ready_1}, 0);
      end
      resp_ready_0 = (win == 1'b0); resp_ready_1 = (win == 1'b1);
      step();
      resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
      mp = ~win;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters: port 0 is the IDU execute path, port 1 is the CSR/branch helper path. The block grants one request at a time using round-robin priority and captures that request's operands. It then drives the ALU's start/operand inputs until the ALU reports done, and returns the registered result to the winning requester over a valid/ready response handshake. A watchdog bounds the wait for the ALU's done signal.

## Interface
- TIMEOUT, default 15 — maximum BUSY cycles to wait for alu_done before an error response; legal range 1..255.
- clk  in  1  — single clock. All state updates on posedge.
- rst  in  1  — synchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1 each  — request present on that port.
- req_ready_0 / req_ready_1  out  1 each  — request accepted this cycle (handshake when valid && ready).
- req_ctrl_0 / req_ctrl_1  in  5 each  — ALU opcode (alu_ctrl encoding).
- req_src1_0, req_src2_0, req_src1_1, req_src2_1  in  32 each  — operands.
- req_csr_0 / req_csr_1  in  32 each  — CSR operand.
- req_inst_0 / req_inst_1  in  32 each  — instruction word (shift-immediate field).
- resp_valid_0 / resp_valid_1  out  1 each  — result available for that port.
- resp_ready_0 / resp_ready_1  in  1 each  — requester consumes the result.
- resp_result  out  32  — shared result bus, valid only with a resp_valid.
- resp_err  out  1  — qualifies resp_result; 1 means timeout.
- alu_go  out  1  — drives the ALU's IDU_done start input.
- alu_ctrl  out  5; alu_src1, alu_src2, alu_csr, alu_inst  out  32 each  — registered operands to the ALU.
- alu_result  in  32; alu_done  in  1  — ALU outputs.

## Operation
- FSM states:
  - IDLE (reset state).
  - BUSY.
  - RESP.
- Priority pointer `prio`, 1 bit, reset 0, names the favoured port.
- IDLE:
  - If exactly one req_valid is high, that port wins.
  - If both are high, port `prio` wins.
  - The winner's req_ready is driven high combinationally. The loser's req_ready is 0.
  - On the handshake:
    - Capture ctrl/src1/src2/csr/inst into the alu_* registers.
    - Record the owner.
    - Clear the watchdog counter.
    - Go to BUSY.
  - If no request is valid, stay in IDLE. All ready outputs are 0 except the combinational grant.
- BUSY:
  - alu_go = 1 and the alu_* operands are held stable.
  - Watchdog counter (8 bits) increments each BUSY cycle.
  - If alu_done = 1: capture alu_result, set err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: set result = 0, err = 1, go to RESP.
  - If alu_done and timeout coincide, alu_done wins (result captured, err = 0).
- RESP:
  - alu_go = 0.
  - resp_valid_<owner> = 1 with resp_result and resp_err held stable until resp_ready_<owner>.
  - On the handshake: prio = ~owner, go to IDLE.
  - resp_ready on the non-owner port is ignored.
- alu_done is ignored outside BUSY. A late done after a timeout is dropped.
- req_ready_* = 0 in BUSY and RESP. At most one request is in flight.
- Reset while in any state:
  - Next cycle the FSM is in IDLE with prio = 0 and counter = 0.
  - The in-flight request is discarded; the requester must re-present it.
- Reset values:
  - req_ready_* = 0, resp_valid_* = 0, resp_result = 0, resp_err = 0.
  - alu_go = 0, alu_ctrl = 0, alu_src1 = alu_src2 = alu_csr = alu_inst = 0.

## Timing
- Accept in cycle N → alu_go high from cycle N+1.
- alu_done sampled high in cycle M (M ≥ N+1) → resp_valid high from M+1.
- With the current ALU (done one cycle after start), the minimum path is accept N → resp_valid N+3:
  - N+1: alu_go rises.
  - N+2: alu_done sampled.
  - N+3: resp_valid.
- Timeout case: resp_valid at N+1+TIMEOUT.
- Response handshake in cycle R → IDLE in R+1; the next accept is possible in R+1.
- Throughput: one operation per 4 cycles minimum.
- No combinational path from alu_done or resp_ready to any output. req_ready depends only on state, req_valid and prio.

## Test plan
- Single request: port 0 with ctrl=00000, src1=5, src2=7; ALU done one cycle after alu_go.
  - Expect req_ready_0 at N, alu_go at N+1, and at N+3 resp_valid_0 = 1, resp_result = 12, resp_err = 0.
- Contention: both ports valid every cycle, resp_ready tied high.
  - Grants alternate 0, 1, 0, 1.
  - Each port receives its own result.
  - resp_valid_1 is never high for a port-0 operation.
- Backpressure: resp_ready_1 held low for 5 cycles.
  - resp_valid_1 and resp_result stay stable.
  - req_ready_0 stays 0 throughout.
  - IDLE is re-entered one cycle after resp_ready_1 rises.
- Timeout: TIMEOUT=4, alu_done held 0.
  - resp_valid at N+5 with resp_result = 0, resp_err = 1.
  - A late alu_done pulse afterwards has no effect.
- Reset mid-BUSY: assert rst for 1 cycle.
  - All outputs 0 the next cycle.
  - prio = 0, so with both ports valid, port 0 is granted first.
- Same-cycle done/timeout: TIMEOUT=2 with alu_done arriving in the second BUSY cycle.
  - resp_err = 0 and resp_result = alu_result.
